// File: rtl/mdiv_host_seq_if.sv
// mdiv_host_seq_if: command, operand-in and result-out streams between the host and the sequencer
//   cmd_valid/cmd_ready/cmd_op/cmd_keep_p : command handshake (op 1 = inverse, keep_p 1 = reuse p)
//   in_valid/in_ready/in_data             : 32-bit operand words, least-significant first
//   out_valid/out_ready/out_data          : 32-bit result words, least-significant first
//   modport master = host side, modport slave = sequencer side
interface mdiv_host_seq_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_op;
    logic        cmd_keep_p;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    modport master (
        output cmd_valid, cmd_op, cmd_keep_p, in_valid, in_data, out_ready,
        input  cmd_ready, in_ready, out_valid, out_data
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_keep_p, in_valid, in_data, out_ready,
        output cmd_ready, in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mdiv_host_seq.sv
// mdiv_host_seq: host-side sequencer for the 256-bit modular inverse/division core
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : command / operand / result streams
//   busy, err           : command in progress, sticky watchdog error
//   core_*              : all control and data pins of the core
//   Optional watchdog in WAIT enabled by defining MDIV_SEQ_TMO_EN (adds parameter TMO_CYCLES).
module mdiv_host_seq #(
    parameter int WORDS = 8
`ifdef MDIV_SEQ_TMO_EN
    , parameter int TMO_CYCLES = 65535
`endif
) (
    input  logic                clk,
    input  logic                rst,
    mdiv_host_seq_if.slave      bus,
    output logic                busy,
    output logic                err,
    output logic [31:0]         core_datain,
    output logic                core_loada,
    output logic                core_loadb,
    output logic                core_loadp,
    output logic                core_en,
    output logic                core_mode,
    output logic                core_outx1,
    output logic                core_outx2,
    input  logic [31:0]         core_x1out,
    input  logic [31:0]         core_x2out,
    input  logic                core_rdy,
    input  logic                core_flag
);
    localparam int CW = $clog2(WORDS) + 1;
    typedef enum logic [2:0] {IDLE, LOAD_P, LOAD_A, LOAD_B, START, WAIT, READ} state_t;
    state_t         state;
    logic [CW-1:0]  cnt;
    logic           sel;
    logic           mode;
    logic           last;
    logic           loading;
    state_t         nxt;
    assign last    = cnt == CW'(WORDS - 1);
    assign loading = state == LOAD_P || state == LOAD_A || state == LOAD_B;
    // inverse skips the b operand
    assign nxt = state == LOAD_P ? LOAD_A : (state == LOAD_A && !mode) ? LOAD_B : START;
    assign bus.cmd_ready = state == IDLE;
    assign bus.in_ready  = loading;
    assign bus.out_valid = state == READ;
    assign bus.out_data  = sel ? core_x2out : core_x1out;
    assign busy          = state != IDLE;
    assign core_datain   = bus.in_data;
    assign core_mode     = mode;
    // strobes are gated by rst so an abort issues no further core strobes in the reset cycle
    assign core_loadp = !rst && state == LOAD_P && bus.in_valid;
    assign core_loada = !rst && state == LOAD_A && bus.in_valid;
    assign core_loadb = !rst && state == LOAD_B && bus.in_valid;
    assign core_en    = !rst && state == START;
    assign core_outx1 = !rst && state == READ && bus.out_ready && !sel;
    assign core_outx2 = !rst && state == READ && bus.out_ready && sel;
`ifdef MDIV_SEQ_TMO_EN
    localparam int TW = $clog2(TMO_CYCLES + 1);
    logic [TW-1:0] tmo;
`else
    assign err = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= 1'b0;
            mode  <= 1'b0;
`ifdef MDIV_SEQ_TMO_EN
            tmo   <= '0;
            err   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    mode  <= bus.cmd_op;
                    state <= bus.cmd_keep_p ? LOAD_A : LOAD_P;
                end
                LOAD_P, LOAD_A, LOAD_B: if (bus.in_valid) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) state <= nxt;
                end
                START: state <= WAIT;
                WAIT: begin
                    if (core_rdy) begin
                        sel   <= core_flag;
                        state <= READ;
                    end
`ifdef MDIV_SEQ_TMO_EN
                    tmo <= core_rdy ? '0 : tmo + 1'b1;
                    if (!core_rdy && tmo == TW'(TMO_CYCLES - 1)) begin
                        err   <= 1'b1;
                        tmo   <= '0;
                        state <= IDLE;
                    end
`endif
                end
                READ: if (bus.out_ready) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdiv_host_seq.sv
// tb_mdiv_host_seq: self-checking bench with a behavioural core model and result scoreboard
module tb_mdiv_host_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    mdiv_host_seq_if bus();
    logic        busy, err;
    logic [31:0] core_datain, core_x1out, core_x2out;
    logic        core_loada, core_loadb, core_loadp, core_en, core_mode, core_outx1, core_outx2;
    logic        core_rdy, core_flag;
    mdiv_host_seq #(
        .WORDS(8)
`ifdef MDIV_SEQ_TMO_EN
        , .TMO_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .err(err),
        .core_datain(core_datain), .core_loada(core_loada), .core_loadb(core_loadb),
        .core_loadp(core_loadp), .core_en(core_en), .core_mode(core_mode),
        .core_outx1(core_outx1), .core_outx2(core_outx2), .core_x1out(core_x1out),
        .core_x2out(core_x2out), .core_rdy(core_rdy), .core_flag(core_flag)
    );
    typedef struct {
        bit op; bit keep; logic [31:0] p; logic [31:0] a; logic [31:0] b;
        bit flag; logic [31:0] r0; bit tog; bit stall; int lat;
        int np; int na; int nb; int nx1; int nx2;
    } vec_t;
    int checks = 0;
    int errors = 0;
    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction
    // core model: result registers shift one word per out strobe, ready pulses lat cycles after en
    logic [31:0] x1m [8];
    logic [31:0] x2m [8];
    logic [3:0]  p1, p2;
    logic        mflag;
    int          cd, rdy_lat;
    assign core_x1out = x1m[p1[2:0]];
    assign core_x2out = x2m[p2[2:0]];
    assign core_flag  = mflag;
    always @(posedge clk) begin
        core_rdy <= 1'b0;
        if (rst) begin
            cd <= 0; p1 <= 4'd0; p2 <= 4'd0;
        end else begin
            if (core_en) begin
                cd <= rdy_lat; p1 <= 4'd0; p2 <= 4'd0;
            end else if (cd > 0) begin
                cd <= cd - 1;
                if (cd == 1) core_rdy <= 1'b1;
            end
            if (core_outx1) p1 <= p1 + 4'd1;
            if (core_outx2) p2 <= p2 + 4'd1;
        end
    end
    // monitor and scoreboard
    logic [33:0] load_q [$];
    logic [31:0] exp_q [$];
    int cyc = 0, cnt_p = 0, cnt_a = 0, cnt_b = 0, cnt_x1 = 0, cnt_x2 = 0, cnt_en = 0, n_ov = 0;
    int last_load = 0, en_cyc = 0, rdy_cyc = 0, ov_cyc = 0;
    bit ov_prev = 0, stall_prev = 0;
    logic [31:0] stall_data;
    always @(negedge clk) begin
        int ns;
        logic [33:0] e;
        cyc++;
        ns = int'(core_loadp) + int'(core_loada) + int'(core_loadb) + int'(core_outx1) + int'(core_outx2) + int'(core_en);
        if (ns != 0) chk("one_strobe", ns <= 1, 1);
        if (core_loadp || core_loada || core_loadb) begin
            last_load = cyc;
            cnt_p += int'(core_loadp); cnt_a += int'(core_loada); cnt_b += int'(core_loadb);
            chk("load_pending", load_q.size() != 0, 1);
            if (load_q.size() != 0) begin
                e = load_q.pop_front();
                chk("load_word", {(core_loadp ? 2'd0 : core_loada ? 2'd1 : 2'd2), core_datain}, e);
            end
        end
        if (core_en) begin en_cyc = cyc; cnt_en++; end
        if (core_rdy) rdy_cyc = cyc;
        if (bus.out_valid && !ov_prev) ov_cyc = cyc;
        if (bus.out_valid) n_ov++;
        if (stall_prev && bus.out_valid) chk("stall_hold", bus.out_data, stall_data);
        if (bus.out_valid && bus.out_ready) begin
            chk("out_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("out_word", bus.out_data, exp_q.pop_front());
        end
        cnt_x1 += int'(core_outx1); cnt_x2 += int'(core_outx2);
        stall_prev = bus.out_valid && !bus.out_ready;
        stall_data = bus.out_data;
        ov_prev = bus.out_valid;
    end
    task automatic setup(input vec_t v);
        rdy_lat = v.lat;
        mflag = v.flag;
        for (int i = 0; i < 8; i++) begin
            x1m[i] = v.flag ? 32'hbad1_0000 + i : (i == 0 ? v.r0 : 32'h0);
            x2m[i] = v.flag ? (i == 0 ? v.r0 : 32'h0) : 32'hbad2_0000 + i;
        end
    endtask
    task automatic issue(input vec_t v);
        int to = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(i == 0 ? v.r0 : 32'h0);
        bus.cmd_valid = 1'b1; bus.cmd_op = v.op; bus.cmd_keep_p = v.keep;
        do begin @(negedge clk); to++; end while (!bus.cmd_ready && to < 100);
        chk("cmd_accept", bus.cmd_ready, 1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
    endtask
    task automatic send_words(input vec_t v);
        logic [31:0] ops [3];
        bit ph = 1'b1;
        ops = '{v.p, v.a, v.b};
        for (int t = (v.keep ? 1 : 0); t < (v.op ? 2 : 3); t++) begin
            for (int w = 0; w < 8; w++) begin
                logic [31:0] d;
                bit acc;
                int to;
                d = (w == 0) ? ops[t] : {8'(t + 1), 16'h0, 8'(w)};
                load_q.push_back({2'(t), d});
                acc = 1'b0; to = 0;
                while (!acc && to < 50) begin
                    bus.in_valid = v.tog ? ph : 1'b1;
                    bus.in_data = d;
                    ph = !ph;
                    @(negedge clk);
                    acc = bus.in_valid && bus.in_ready;
                    to++;
                    @(posedge clk); #1;
                end
                chk("word_accept", acc, 1);
            end
        end
        bus.in_valid = 1'b0;
    endtask
    task automatic recv(input bit stall, input int stop);
        int n = 0, sc = 0, to = 0;
        while (n < stop && to < 300) begin
            bus.out_ready = !(stall && n == 2 && sc < 3);
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) n++;
            else if (bus.out_valid) sc++;
            to++;
            @(posedge clk); #1;
        end
        chk("recv_count", n, stop);
    endtask
    task automatic run_vec(input vec_t v);
        int sp = cnt_p, sa = cnt_a, sb = cnt_b, s1 = cnt_x1, s2 = cnt_x2, se = cnt_en;
        setup(v);
        issue(v);
        send_words(v);
        recv(v.stall, 8);
        bus.out_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("n_loadp", cnt_p - sp, v.np);
        chk("n_loada", cnt_a - sa, v.na);
        chk("n_loadb", cnt_b - sb, v.nb);
        chk("n_outx1", cnt_x1 - s1, v.nx1);
        chk("n_outx2", cnt_x2 - s2, v.nx2);
        chk("n_en", cnt_en - se, 1);
        chk("en_latency", en_cyc - last_load, 1);
        chk("ov_latency", ov_cyc - rdy_cyc, 1);
        chk("mode", core_mode, v.op);
        chk("busy_end", busy, 0);
        chk("exp_q_empty", exp_q.size(), 0);
    endtask
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_no_strobe", {core_loadp, core_loada, core_loadb, core_en, core_outx1, core_outx2}, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        load_q.delete();
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_outputs", {bus.in_ready, bus.out_valid, core_loadp, core_loada, core_loadb,
                            core_en, core_outx1, core_outx2, err}, 0);
        @(posedge clk); #1;
    endtask
    vec_t tbl [4];
    initial begin
        vec_t v;
        int s;
        bus.cmd_valid = 1'b0; bus.cmd_op = 1'b0; bus.cmd_keep_p = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.out_ready = 1'b0;
        mflag = 1'b0; rdy_lat = 1;
        for (int i = 0; i < 8; i++) begin x1m[i] = 32'h0; x2m[i] = 32'h0; end
        tbl[0] = '{1'b1, 1'b0, 32'd7,  32'd3, 32'd0, 1'b0, 32'd5, 1'b0, 1'b0, 3, 8, 8, 0, 8, 0};
        tbl[1] = '{1'b0, 1'b0, 32'd11, 32'd2, 32'd3, 1'b1, 32'd7, 1'b0, 1'b0, 4, 8, 8, 8, 0, 8};
        tbl[2] = '{1'b1, 1'b1, 32'd0,  32'd3, 32'd0, 1'b0, 32'd5, 1'b0, 1'b0, 2, 0, 8, 0, 8, 0};
        tbl[3] = '{1'b0, 1'b0, 32'd11, 32'd2, 32'd3, 1'b1, 32'd7, 1'b1, 1'b1, 5, 8, 8, 8, 0, 8};
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("init_cmd_ready", bus.cmd_ready, 1);
        chk("init_busy", busy, 0);
        chk("init_outputs", {bus.in_ready, bus.out_valid, core_loadp, core_loada, core_loadb,
                             core_en, core_outx1, core_outx2, core_mode, err}, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) run_vec(tbl[i]);
        // reset while waiting for the core
        v = tbl[0];
        v.lat = 50;
        setup(v);
        issue(v);
        send_words(v);
        repeat (3) @(negedge clk);
        chk("in_wait", {busy, bus.in_ready, bus.out_valid}, 3'b100);
        @(posedge clk); #1;
        do_reset();
        // reset after four result words, with out_ready still high
        v = tbl[0];
        s = cnt_x1;
        setup(v);
        issue(v);
        send_words(v);
        recv(1'b0, 4);
        do_reset();
        bus.out_ready = 1'b0;
        chk("x1_before_rst", cnt_x1 - s, 4);
        run_vec(tbl[0]);
`ifdef MDIV_SEQ_TMO_EN
        v = tbl[2];
        v.lat = 0;
        setup(v);
        s = n_ov;
        issue(v);
        exp_q.delete();
        send_words(v);
        repeat (10) @(negedge clk);
        chk("tmo_err_early", err, 0);
        begin
            int to = 0;
            while (busy && to < 40) begin @(negedge clk); to++; end
        end
        chk("tmo_err", err, 1);
        chk("tmo_idle", busy, 0);
        chk("tmo_no_out", n_ov - s, 0);
        @(posedge clk); #1;
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
